// File: rtl/jk_bank_arbiter.sv
// Round-robin 4-way arbiter that applies one masked JK command per slot to a shared WIDTH-bit bank.
// Latency: grant +1, new Q and done +2, next arbitration +3; requesters hold req until done, there is no other backpressure.
module jk_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [3:0]         req,
    input  logic [7:0]         cmd_bus,
    input  logic [4*WIDTH-1:0] mask_bus,
    output logic [3:0]         gnt,
    output logic [3:0]         done,
    output logic               busy,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   QNEG
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_win;
    logic [1:0]       r_cmd;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_q;
    logic [3:0]       r_gnt;
    logic [3:0]       r_done;

    logic [1:0]       w_win;
    logic [1:0]       w_cmd;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_q_next;

    // Scan from the highest offset down so the requester closest to the pointer wins.
    always_comb begin
        w_win = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_win = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_cmd  = cmd_bus[1:0];
        w_mask = mask_bus[WIDTH-1:0];
        case (w_win)
            2'd0: begin
                w_cmd  = cmd_bus[1:0];
                w_mask = mask_bus[WIDTH*0 +: WIDTH];
            end
            2'd1: begin
                w_cmd  = cmd_bus[3:2];
                w_mask = mask_bus[WIDTH*1 +: WIDTH];
            end
            2'd2: begin
                w_cmd  = cmd_bus[5:4];
                w_mask = mask_bus[WIDTH*2 +: WIDTH];
            end
            default: begin
                w_cmd  = cmd_bus[7:6];
                w_mask = mask_bus[WIDTH*3 +: WIDTH];
            end
        endcase
    end

    // Per-bit JK with {J,K} encoding, restricted to the latched mask.
    always_comb begin
        w_q_next = r_q;
        case (r_cmd)
            2'b01:   w_q_next = r_q & ~r_mask;
            2'b10:   w_q_next = r_q | r_mask;
            2'b11:   w_q_next = r_q ^ r_mask;
            default: w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_win   <= 2'd0;
            r_cmd   <= 2'b00;
            r_mask  <= '0;
            r_q     <= '0;
            r_gnt   <= 4'b0000;
            r_done  <= 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 4'b0000;
                    if (|req) begin
                        r_win   <= w_win;
                        r_cmd   <= w_cmd;
                        r_mask  <= w_mask;
                        r_gnt   <= 4'b0001 << w_win;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_q     <= w_q_next;
                    r_done  <= r_gnt;
                    r_gnt   <= 4'b0000;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 4'b0000;
                    r_ptr   <= r_win + 2'd1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= 4'b0000;
                    r_done  <= 4'b0000;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = (r_state != ST_IDLE);
    assign Q    = r_q;
    assign QNEG = ~r_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: stimulus queues expected grants/completions, a negedge monitor checks them.
module tb_jk_bank_arbiter;

    logic        clk = 1'b0;
    logic        clear;
    logic [3:0]  req;
    logic [7:0]  cmd_bus;
    logic [31:0] mask_bus;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  Q;
    logic [7:0]  QNEG;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    typedef struct {
        int         cyc;
        logic [3:0] oh;
        logic [7:0] q;
    } exp_t;

    exp_t gq[$];
    exp_t dq[$];

    jk_bank_arbiter #(.WIDTH(8)) dut (
        .clk      (clk),
        .clear    (clear),
        .req      (req),
        .cmd_bus  (cmd_bus),
        .mask_bus (mask_bus),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .Q        (Q),
        .QNEG     (QNEG)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: invariants every cycle, grant/done pops from the scoreboard queues.
    always @(negedge clk) begin
        exp_t e;
        logic inv_ok;
        if (started) begin
            inv_ok = (QNEG == ~Q) && (busy == ((gnt != 4'b0) || (done != 4'b0)))
                     && ((gnt & done) == 4'b0) && $onehot0(gnt) && $onehot0(done);
            check("invariants", 32'(inv_ok), 32'd1);
            if (gnt != 4'b0) begin
                if (gq.size() == 0) begin
                    check("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    e = gq.pop_front();
                    check("gnt_value", 32'(gnt), 32'(e.oh));
                    check("gnt_cycle", cyc, e.cyc);
                end
            end
            if (done != 4'b0) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = dq.pop_front();
                    check("done_value", 32'(done), 32'(e.oh));
                    check("done_cycle", cyc, e.cyc);
                    check("q_value", 32'(Q), 32'(e.q));
                end
            end
        end
    end

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_op(input int idx, input logic [1:0] cmd, input logic [7:0] mask,
                         input logic [7:0] expq, input bit iso);
        int t;
        exp_t e;
        @(negedge clk);
        req                  = 4'b0001 << idx;
        cmd_bus[2*idx +: 2]  = cmd;
        mask_bus[8*idx +: 8] = mask;
        t = cyc + 1;
        e.cyc = t;
        e.oh  = 4'b0001 << idx;
        e.q   = expq;
        gq.push_back(e);
        e.cyc = t + 1;
        dq.push_back(e);
        wait_cyc(t);
        if (iso) begin
            cmd_bus[2*idx +: 2]  = ~cmd;
            mask_bus[8*idx +: 8] = 8'hFF;
        end
        wait_cyc(t + 2);
        req = 4'b0000;
        @(negedge clk);
        check("busy_after_op", 32'(busy), 32'd0);
    endtask

    // All four request; each winner drops req for the arbitration edge right after its done.
    task automatic run_rr(input int first, input int n, input logic [39:0] eqs);
        int t;
        int w;
        exp_t e;
        @(negedge clk);
        req = 4'b1111;
        t = cyc + 1;
        for (int k = 0; k < n; k++) begin
            w = (first + k) % 4;
            e.cyc = t + 3 * k;
            e.oh  = 4'b0001 << w;
            e.q   = eqs[8*k +: 8];
            gq.push_back(e);
            e.cyc = t + 3 * k + 1;
            dq.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            w = (first + k) % 4;
            wait_cyc(t + 3 * k + 2);
            if (k == n - 1) req = 4'b0000;
            else            req[w] = 1'b0;
            wait_cyc(t + 3 * k + 3);
            if (k < n - 1) req[w] = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        exp_t e;
        clear    = 1'b1;
        req      = 4'b1111;
        cmd_bus  = 8'h00;
        mask_bus = 32'h0;

        // Reset held two cycles with every requester asserted.
        @(posedge clk);
        #1 started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_q",    32'(Q),    32'h00);
            check("rst_qneg", 32'(QNEG), 32'hFF);
            check("rst_gnt",  32'(gnt),  32'h0);
            check("rst_done", 32'(done), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
        end
        clear = 1'b0;
        req   = 4'b0000;

        do_op(0, 2'b10, 8'h0F, 8'h0F, 1'b0);
        check("qneg_after_set", 32'(QNEG), 32'hF0);
        do_op(2, 2'b11, 8'hFF, 8'hF0, 1'b0);
        do_op(2, 2'b01, 8'h30, 8'hC0, 1'b0);
        do_op(2, 2'b00, 8'hFF, 8'hC0, 1'b0);
        do_op(1, 2'b10, 8'h0F, 8'hCF, 1'b1);

        // Abort an in-flight set with clear during EXEC.
        pulse_clear();
        check("clr_q", 32'(Q), 32'h00);
        @(negedge clk);
        req              = 4'b1000;
        cmd_bus[7:6]     = 2'b10;
        mask_bus[31:24]  = 8'hFF;
        t = cyc + 1;
        e.cyc = t;
        e.oh  = 4'b1000;
        e.q   = 8'h00;
        gq.push_back(e);
        wait_cyc(t);
        clear = 1'b1;
        wait_cyc(t + 1);
        clear = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        check("abort_q",    32'(Q),    32'h00);
        check("abort_done", 32'(done), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_gnt",  32'(gnt),  32'h0);
        @(negedge clk);
        check("abort_done_late", 32'(done), 32'h0);

        // Round-robin from reset: r0 tog 03, r1 set 10, r2 rst 01, r3 tog F0.
        cmd_bus  = 8'b11_01_10_11;
        mask_bus = {8'hF0, 8'h01, 8'h10, 8'h03};
        run_rr(0, 5, {8'hE1, 8'hE2, 8'h12, 8'h13, 8'h03});

        // Lone serve of r0 (empty mask) after reset moves the pointer to 1.
        pulse_clear();
        do_op(0, 2'b00, 8'h00, 8'h00, 1'b0);
        cmd_bus  = 8'b11_01_10_11;
        mask_bus = {8'hF0, 8'h01, 8'h10, 8'h03};
        run_rr(1, 4, {8'h00, 8'hE3, 8'hE0, 8'h10, 8'h10});

        repeat (4) @(negedge clk);
        check("gnt_queue_empty",  gq.size(), 32'd0);
        check("done_queue_empty", dq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
